// File: rtl/aes_pkg.sv
// Shared AES byte-substitution resources: FIPS-197 S-box tables, the lookup helper
// and the SubBytes engine state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Single-byte substitution; inv selects the inverse table.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] b_in,
    input  logic       inv,
    output logic [7:0] b_out
);

    assign b_out = sub_byte(b_in, inv);

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Multi-beat SubBytes/InvSubBytes engine: LANES bytes of the work register are substituted
// per cycle, walking from byte 0 (MSB) towards the last byte.
module aes_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 16,
    parameter int unsigned LANES      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data
);

    localparam int unsigned NBEATS = WORD_BYTES / LANES;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned W      = 8 * WORD_BYTES;

    if ((WORD_BYTES % LANES) != 0) begin : g_bad_cfg
        $error("WORD_BYTES must be a multiple of LANES");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     work_q, work_d;
    logic             inv_q, inv_d;
    logic [31:0]      base;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    // Index of the first byte of the current chunk.
    assign base = 32'(cnt_q) * LANES;

    // Chunk mux: byte k lives at bit offset W-8*(k+1) since byte 0 is the MSB.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_in[i] = 8'(work_q >> (W - 8 * (base + i + 1)));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lane u_lane (
            .b_in  (lane_in[g]),
            .inv   (inv_q),
            .b_out (lane_out[g])
        );
    end

    // Next-state, counter, work-register update and in_ready.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        inv_d    = inv_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = rst_n;
                if (in_valid) begin
                    work_d  = in_data;
                    inv_d   = in_inv;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int i = 0; i < LANES; i++) begin
                    work_d = (work_d & ~(W'(8'hff) << (W - 8 * (base + i + 1))))
                           | (W'(lane_out[i]) << (W - 8 * (base + i + 1)));
                end
                if (cnt_q == CNT_W'(NBEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                // A new word may only enter on the edge that retires the current one.
                in_ready = out_ready & rst_n;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_data;
                        inv_d   = in_inv;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_data  = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Self-checking bench for aes_sub_bytes_engine; the reference S-box is derived from
// GF(2^8) inversion plus the AES affine map, independent of the RTL tables.
module tb_aes_sub_bytes_engine;

    localparam int unsigned W = 128;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_inv, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [W-1:0] out_data_a, out_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    always #5 clk = ~clk;

    aes_sub_bytes_engine #(.WORD_BYTES(16), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    aes_sub_bytes_engine #(.WORD_BYTES(16), .LANES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a)
    );

    aes_sub_bytes_engine #(.WORD_BYTES(16), .LANES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = 8'(d >> (8 * (15 - k)));
            r = (r << 8) | W'(inv ? inv_tbl[b] : fwd_tbl[b]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with junk on the inputs while the engine is busy.
    task automatic send_word(input logic [W-1:0] d, input logic inv,
                             output logic [W-1:0] res, output int lat);
        int guard;
        guard = 0;
        out_ready = 1'b0;
        while (!in_ready && guard < 50) begin tick(); guard++; end
        in_valid = 1'b1; in_data = d; in_inv = inv;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_inv   = 1'($urandom());
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        res = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] pt, ct, held, r1, r2, x16, ed16;
        logic [W-1:0] words [8];
        logic [W-1:0] exp_q [$];
        logic [7:0]   xb;
        int lat, lat2, idx, oidx, cyc, last_cyc, nv, lm, la, lb;
        logic acc, cons;
        logic [W-1:0] obs;

        for (int i = 0; i < 256; i++) begin
            fwd_tbl[i] = sbox_calc(8'(i));
            inv_tbl[fwd_tbl[i]] = 8'(i);
        end
        pt = 128'h00112233445566778899aabbccddeeff;
        ct = 128'h638293c31bfc33f5c4eeacea4bc12816;

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_bit("idle_in_ready", in_ready, 1'b1);

        // Forward known answer, latency and backpressure
        in_valid = 1'b1; in_data = pt; in_inv = 1'b0;
        tick();
        in_valid = 1'b0; in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk_int("fwd_latency", lat, 4);
        chk("fwd_kat", out_data, ct);
        chk("fwd_model", out_data, model_word(pt, 1'b0));
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_bit("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, held);
            chk_bit("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b1; in_data = ct; in_inv = 1'b1; out_ready = 1'b1;
        #1;
        chk_bit("release_in_ready", in_ready, 1'b1);
        tick();
        chk_bit("b2b_busy_out_valid", out_valid, 1'b0);
        chk_bit("b2b_busy_in_ready", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; in_inv = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk_int("inv_latency", lat, 4);
        chk("inv_kat", out_data, pt);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Round-trip sweep over every byte value
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            x16 = {16{xb}};
            send_word(x16, 1'b0, r1, lat);
            chk($sformatf("sweep_fwd_%02h", xb), r1, model_word(x16, 1'b0));
            send_word(r1, 1'b1, r2, lat2);
            chk($sformatf("sweep_inv_%02h", xb), r2, x16);
        end

        // Stream of 8 words, alternating mode, consumer always ready
        for (int k = 0; k < 8; k++) begin
            words[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_q.push_back(model_word(words[k], 1'(k)));
        end
        idx = 0; oidx = 0; last_cyc = -1;
        in_valid = 1'b1; in_data = words[0]; in_inv = 1'b0; out_ready = 1'b1;
        for (cyc = 0; cyc < 200 && oidx < 8; cyc++) begin
            acc  = in_valid & in_ready;
            cons = out_valid & out_ready;
            obs  = out_data;
            tick();
            if (cons) begin
                chk($sformatf("stream_word_%0d", oidx), obs, exp_q.pop_front());
                if (last_cyc >= 0) chk_int("stream_spacing", cyc - last_cyc, 5);
                last_cyc = cyc;
                oidx++;
            end
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    in_data = words[idx]; in_inv = 1'(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk_int("stream_count", oidx, 8);
        in_valid = 1'b0; out_ready = 1'b0; in_inv = 1'b0;
        tick();

        // Reset in the middle of a word
        in_valid = 1'b1; in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        chk_bit("midrst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_bit("postrst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1; nv = 0;
        for (int c = 0; c < 20; c++) begin tick(); if (out_valid) nv++; end
        chk_int("aborted_word_absent", nv, 0);
        out_ready = 1'b0;

        // One-beat and sixteen-beat configurations
        ed16 = {16{8'hed}};
        in_valid = 1'b1; in_data = {16{8'h53}}; in_inv = 1'b0;
        tick();
        in_valid = 1'b0;
        lm = -1; la = -1; lb = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid && lm < 0) lm = c;
            if (out_valid_a && la < 0) la = c;
            if (out_valid_b && lb < 0) lb = c;
        end
        chk_int("lanes4_latency", lm, 4);
        chk_int("lanes16_latency", la, 1);
        chk_int("lanes1_latency", lb, 16);
        chk("lanes4_data", out_data, ed16);
        chk("lanes16_data", out_data_a, ed16);
        chk("lanes1_data", out_data_b, ed16);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
